control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 16, instruction register width.
REQ-002 SHALL have parameter RF_ADDR_WIDTH, default 4, register-file address width for 16 registers.
REQ-003 SHALL have parameter D_ADDR_WIDTH, default 8, data-memory address width.
REQ-004 SHALL have the port Clk  input  1  single clock; all state changes occur on its rising edge.
REQ-005 SHALL have the port Reset  input  1  reset; synchronous and active-high.
REQ-006 SHALL have the port IR  input  IR_WIDTH  current instruction, from the IR register.
REQ-007 SHALL have the ports PC_Clr, PC_Up, IR_Ld  output  1 each  program-counter clear, program-counter increment, and IR load.
REQ-008 SHALL have the ports D_Addr  output  D_ADDR_WIDTH, and D_Wr  output  1, for data-memory address and write strobe.
REQ-009 SHALL have the ports RF_s  output  1  write-data mux select (1 = memory, 0 = ALU), and ALU_s0  output  3  ALU operation.
REQ-010 SHALL have the ports RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr  output  RF_ADDR_WIDTH each, and RF_W_En  output  1, for the register-file write port and two read ports.
REQ-011 SHALL have the port State  output  4  current state encoding, for debug.

Function
REQ-012 SHALL implement a Moore FSM with these states: Init, Fetch, Decode, Noop, Load, Store, Add, Sub, Halt; all outputs are a function of the state and IR only.
REQ-013 SHALL drive every output to 0 in any state that does not name it.
REQ-014 SHALL assert PC_Clr in Init for one cycle, then go to Fetch.
REQ-015 SHALL assert PC_Up and IR_Ld together in Fetch, then go to Decode.
REQ-016 SHALL branch in Decode on IR[15:12] as follows: 0000 -> Noop, 0001 -> Store, 0010 -> Load, 0011 -> Add, 0100 -> Sub, 0101 -> Halt, and any other value -> Noop.
REQ-017 SHALL, in Store, drive RF_Ra_Addr=IR[11:8] and D_Addr=IR[7:0], assert D_Wr, then go to Fetch.
REQ-018 SHALL, in Load, drive D_Addr=IR[11:4], RF_W_Addr=IR[3:0] and RF_s=1, assert RF_W_En, then go to Fetch.
REQ-019 SHALL, in Add or Sub, drive RF_Ra_Addr=IR[11:8], RF_Rb_Addr=IR[7:4], RF_W_Addr=IR[3:0] and RF_s=0, set ALU_s0 to 1 for Add or 2 for Sub, assert RF_W_En, then go to Fetch.
REQ-020 SHALL go from Noop to Fetch with no outputs asserted.
REQ-021 SHALL hold in Halt, with all outputs 0, until Reset is asserted.
REQ-022 SHALL take 3 cycles per instruction (Fetch, Decode, execute), measured from one Fetch to the next.
REQ-023 SHALL never assert D_Wr and RF_W_En in the same cycle.

Reset
REQ-024 SHALL enter Init on the next rising edge of Clk whenever Reset is 1, from any state including Halt.
REQ-025 SHALL NOT suppress the RF_W_En or D_Wr that is already asserted in the cycle Reset is sampled; that write completes, because downstream storage has no reset.
REQ-026 SHALL present Init outputs after reset: PC_Clr=1, all other outputs 0, and State = the Init encoding.

Configuration
REQ-027 SHALL support the macro CU_LOAD_WAIT_EN.
  - When defined: Load is split into Load_A and Load_B, for a synchronous-read data memory.
  - Load_A drives D_Addr only.
  - Load_B holds D_Addr, drives RF_s=1, and asserts RF_W_En.
  - Load therefore takes 4 cycles.
  - When undefined: Load is a single state, as specified in REQ-018.

Structure
REQ-028 SHALL take the following from shared package cu_pkg:
  - the state enum;
  - the opcode localparams (NOOP, STORE, LOAD, ADD, SUB, HALT);
  - the ALU select constants (ALU_PASS=0, ALU_ADD=1, ALU_SUB=2).
REQ-029 SHALL be a single module with no sub-module: one state register plus one combinational next-state/output block.

Verification
REQ-030 SHALL cover this scenario: Reset=1 for 1 cycle -> State=Init, PC_Clr=1; the next cycle is Fetch, with PC_Up=IR_Ld=1.
REQ-031 SHALL cover this scenario: IR=16'h3125 (ADD) at Decode -> in Add: Ra=1, Rb=2, W_Addr=5, ALU_s0=1, RF_W_En=1, RF_s=0; the next state is Fetch.
REQ-032 SHALL cover this scenario: IR=16'h1A3C (STORE) -> Ra=4'hA, D_Addr=8'h3C, D_Wr=1, RF_W_En=0.
REQ-033 SHALL cover this scenario: IR=16'h2F07 (LOAD) -> D_Addr=8'hF0, W_Addr=7, RF_s=1, RF_W_En=1 in 1 cycle, or in the second cycle when CU_LOAD_WAIT_EN is defined.
REQ-034 SHALL cover this scenario: IR=16'h5000 (HALT) -> the FSM stays in Halt for 10 cycles with all outputs 0; Reset=1 -> Init.
REQ-035 SHALL cover this scenario: IR=16'hF000 (unknown opcode) -> Noop then Fetch; Reset asserted during Sub -> that cycle's RF_W_En still completes, and the next state is Init.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared types and constants for the control unit.
// CU_LOAD_WAIT_EN adds the S_LOAD_B state for synchronous-read memory.
package cu_pkg;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD   = 4'd4,
    S_STORE  = 4'd5,
    S_ADD    = 4'd6,
    S_SUB    = 4'd7,
    S_HALT   = 4'd8,
    S_LOAD_B = 4'd9
  } state_t;

  localparam logic [3:0] NOOP  = 4'h0;
  localparam logic [3:0] STORE = 4'h1;
  localparam logic [3:0] LOAD  = 4'h2;
  localparam logic [3:0] ADD   = 4'h3;
  localparam logic [3:0] SUB   = 4'h4;
  localparam logic [3:0] HALT  = 4'h5;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

endpackage

// File: rtl/control_unit.sv
// Moore FSM sequencing fetch/decode/execute for the datapath.
// Define CU_LOAD_WAIT_EN to split Load into S_LOAD (addr) and S_LOAD_B.
module control_unit
  import cu_pkg::*;
#(
  parameter int IR_WIDTH      = 16,
  parameter int RF_ADDR_WIDTH = 4,
  parameter int D_ADDR_WIDTH  = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [IR_WIDTH-1:0]      IR,
  output logic                     PC_Clr,
  output logic                     PC_Up,
  output logic                     IR_Ld,
  output logic [D_ADDR_WIDTH-1:0]  D_Addr,
  output logic                     D_Wr,
  output logic                     RF_s,
  output logic [2:0]               ALU_s0,
  output logic [RF_ADDR_WIDTH-1:0] RF_W_Addr,
  output logic [RF_ADDR_WIDTH-1:0] RF_Ra_Addr,
  output logic [RF_ADDR_WIDTH-1:0] RF_Rb_Addr,
  output logic                     RF_W_En,
  output logic [3:0]               State
);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] op;

  assign op    = IR[15:12];
  assign State = state;

  always_ff @(posedge Clk) begin
    if (Reset)
      state <= S_INIT;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    PC_Clr     = 1'b0;
    PC_Up      = 1'b0;
    IR_Ld      = 1'b0;
    D_Addr     = '0;
    D_Wr       = 1'b0;
    RF_s       = 1'b0;
    ALU_s0     = ALU_PASS;
    RF_W_Addr  = '0;
    RF_Ra_Addr = '0;
    RF_Rb_Addr = '0;
    RF_W_En    = 1'b0;
    unique case (state)
      S_INIT: begin
        PC_Clr    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        PC_Up     = 1'b1;
        IR_Ld     = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          (op == STORE): state_nxt = S_STORE;
          (op == LOAD):  state_nxt = S_LOAD;
          (op == ADD):   state_nxt = S_ADD;
          (op == SUB):   state_nxt = S_SUB;
          (op == HALT):  state_nxt = S_HALT;
          default:       state_nxt = S_NOOP;
        endcase
      end
      S_STORE: begin
        RF_Ra_Addr = RF_ADDR_WIDTH'(IR[11:8]);
        D_Addr     = D_ADDR_WIDTH'(IR[7:0]);
        D_Wr       = 1'b1;
        state_nxt  = S_FETCH;
      end
`ifdef CU_LOAD_WAIT_EN
      S_LOAD: begin
        D_Addr    = D_ADDR_WIDTH'(IR[11:4]);
        state_nxt = S_LOAD_B;
      end
      S_LOAD_B: begin
        D_Addr    = D_ADDR_WIDTH'(IR[11:4]);
        RF_W_Addr = RF_ADDR_WIDTH'(IR[3:0]);
        RF_s      = 1'b1;
        RF_W_En   = 1'b1;
        state_nxt = S_FETCH;
      end
`else
      S_LOAD: begin
        D_Addr    = D_ADDR_WIDTH'(IR[11:4]);
        RF_W_Addr = RF_ADDR_WIDTH'(IR[3:0]);
        RF_s      = 1'b1;
        RF_W_En   = 1'b1;
        state_nxt = S_FETCH;
      end
`endif
      S_ADD, S_SUB: begin
        RF_Ra_Addr = RF_ADDR_WIDTH'(IR[11:8]);
        RF_Rb_Addr = RF_ADDR_WIDTH'(IR[7:4]);
        RF_W_Addr  = RF_ADDR_WIDTH'(IR[3:0]);
        ALU_s0     = (state == S_ADD) ? ALU_ADD : ALU_SUB;
        RF_W_En    = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_NOOP:  state_nxt = S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: directed per-cycle vectors.
// Honours CU_LOAD_WAIT_EN for the Load sequence.
module tb_control_unit;

  localparam logic [3:0] ST_INIT = 4'd0, ST_FETCH = 4'd1, ST_DEC = 4'd2;
  localparam logic [3:0] ST_NOOP = 4'd3, ST_LOAD = 4'd4, ST_STORE = 4'd5;
  localparam logic [3:0] ST_ADD = 4'd6, ST_SUB = 4'd7, ST_HALT = 4'd8;
  localparam logic [3:0] ST_LOADB = 4'd9;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] IR;
  logic        PC_Clr, PC_Up, IR_Ld, D_Wr, RF_s, RF_W_En;
  logic [7:0]  D_Addr;
  logic [2:0]  ALU_s0;
  logic [3:0]  RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr, State;

  typedef struct {
    logic [32:0] v;
    string       name;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   done   = 0;

  control_unit dut (
    .Clk(Clk), .Reset(Reset), .IR(IR),
    .PC_Clr(PC_Clr), .PC_Up(PC_Up), .IR_Ld(IR_Ld),
    .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s), .ALU_s0(ALU_s0),
    .RF_W_Addr(RF_W_Addr), .RF_Ra_Addr(RF_Ra_Addr),
    .RF_Rb_Addr(RF_Rb_Addr), .RF_W_En(RF_W_En), .State(State)
  );

  always #5 Clk = ~Clk;

  function automatic logic [32:0] mk(
    logic [3:0] st, logic clr, logic up, logic ld,
    logic [7:0] da, logic wr, logic s, logic [2:0] alu,
    logic [3:0] wa, logic [3:0] ra, logic [3:0] rb, logic wen);
    return {st, clr, up, ld, da, wr, s, alu, wa, ra, rb, wen};
  endfunction

  function automatic logic [32:0] idle(logic [3:0] st);
    return mk(st, 0, 0, 0, 8'h00, 0, 0, 3'd0, 4'h0, 4'h0, 4'h0, 0);
  endfunction

  // Drive inputs for the next edge and queue the outputs that edge must yield.
  task automatic step(logic rst, logic [15:0] ir, logic [32:0] e,
                      string name);
    exp_t x;
    @(negedge Clk);
    #1;
    Reset  = rst;
    IR     = ir;
    x.v    = e;
    x.name = name;
    q.push_back(x);
  endtask

  task automatic fetch_decode(logic [15:0] ir);
    step(0, ir, mk(ST_FETCH, 0, 1, 1, 8'h00, 0, 0, 3'd0, 4'h0, 4'h0, 4'h0, 0),
         "fetch");
    step(0, ir, idle(ST_DEC), "decode");
  endtask

  always @(negedge Clk) begin
    logic [32:0] act;
    exp_t        x;
    if (!done && q.size() > 0) begin
      act = {State, PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s, ALU_s0,
             RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr, RF_W_En};
      x = q.pop_front();
      checks++;
      if (act !== x.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", x.name, act, x.v);
      end
      checks++;
      if (D_Wr && RF_W_En) begin
        errors++;
        $display("FAIL wr_excl: D_Wr=%b RF_W_En=%b expected not both",
                 D_Wr, RF_W_En);
      end
    end
  end

  initial begin
    Reset = 1'b1;
    IR    = 16'h0000;
    q.push_back('{mk(ST_INIT, 1, 0, 0, 8'h00, 0, 0, 3'd0, 4'h0, 4'h0, 4'h0, 0),
                  "reset_init"});

    fetch_decode(16'h3125);
    step(0, 16'h3125,
         mk(ST_ADD, 0, 0, 0, 8'h00, 0, 0, 3'd1, 4'h5, 4'h1, 4'h2, 1), "add");

    fetch_decode(16'h1A3C);
    step(0, 16'h1A3C,
         mk(ST_STORE, 0, 0, 0, 8'h3C, 1, 0, 3'd0, 4'h0, 4'hA, 4'h0, 0), "store");

    fetch_decode(16'h2F07);
`ifdef CU_LOAD_WAIT_EN
    step(0, 16'h2F07,
         mk(ST_LOAD, 0, 0, 0, 8'hF0, 0, 0, 3'd0, 4'h0, 4'h0, 4'h0, 0), "load_a");
    step(0, 16'h2F07,
         mk(ST_LOADB, 0, 0, 0, 8'hF0, 0, 1, 3'd0, 4'h7, 4'h0, 4'h0, 1), "load_b");
`else
    step(0, 16'h2F07,
         mk(ST_LOAD, 0, 0, 0, 8'hF0, 0, 1, 3'd0, 4'h7, 4'h0, 4'h0, 1), "load");
`endif

    fetch_decode(16'hF000);
    step(0, 16'hF000, idle(ST_NOOP), "noop_unknown");

    fetch_decode(16'h0000);
    step(0, 16'h0000, idle(ST_NOOP), "noop");

    fetch_decode(16'h6FFF);
    step(0, 16'h6FFF, idle(ST_NOOP), "noop_op6");

    fetch_decode(16'h4321);
    step(0, 16'h4321,
         mk(ST_SUB, 0, 0, 0, 8'h00, 0, 0, 3'd2, 4'h1, 4'h3, 4'h2, 1), "sub");
    step(1, 16'h4321,
         mk(ST_INIT, 1, 0, 0, 8'h00, 0, 0, 3'd0, 4'h0, 4'h0, 4'h0, 0),
         "reset_from_sub");

    fetch_decode(16'h5000);
    step(0, 16'h5000, idle(ST_HALT), "halt_enter");
    for (int i = 0; i < 10; i++)
      step(0, 16'h5000, idle(ST_HALT), "halt_hold");
    step(1, 16'h5000,
         mk(ST_INIT, 1, 0, 0, 8'h00, 0, 0, 3'd0, 4'h0, 4'h0, 4'h0, 0),
         "reset_from_halt");
    step(0, 16'h0000,
         mk(ST_FETCH, 0, 1, 1, 8'h00, 0, 0, 3'd0, 4'h0, 4'h0, 4'h0, 0),
         "fetch_after_halt");

    repeat (2) @(negedge Clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    done = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
